sdc_mc: RTL and testbench
=========================

# sdc_mc

Multi-channel, parametrised SPI controller for SD cards and other SPI peripherals on the RISC5 I/O bus. It is the successor to the single-card SD interface and adds:
- up to four chip selects
- 8- or 32-bit transfers selectable per transfer
- parametrised slow/fast clock dividers
- a sticky overrun flag
- an optional completion interrupt

It sits on the I/O bus decode as a word-addressed slave with three registers.

## Interface
Parameters:
- NUM_CS, 2, number of chip-select outputs (1..4)
- SLOW_DIV, 63, half-period of sclk in clk cycles in slow mode (≥1); at 50 MHz gives ≈397 kHz
- FAST_DIV, 2, half-period of sclk in clk cycles in fast mode (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- stb  in  1  bus strobe
- we  in  1  write enable
- addr  in  2  register select: 0 data, 1 control, 2 status
- data_in  in  32  write data
- data_out  out  32  read data; 0 when not reading
- ack  out  1  = stb (zero wait states)
- ss_n  out  NUM_CS  active-low chip selects
- sclk  out  1  SPI clock, mode 0
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- irq  out  1  completion interrupt (see Configuration)

## Operation
Register 0, data:
- Write starts a transfer if the engine is idle.
- Write while busy is ignored and sets ovr.
- Read returns the last received word; in 8-bit mode the value is {24'h0, byte}.

Register 1, control (write only; reads return 0):
- [NUM_CS-1:0] sel: ss_n = ~sel. Takes effect immediately.
- [8] fast.
- [9] wide (1 = 32-bit).
- [10] ien.
- [31] writing 1 clears ovr; the bit is not stored.

Register 2, status (read only): {28'h0, ovr, done, busy, rdy}, where rdy = ~busy.

Engine behaviour:
- SPI mode 0: sclk idles 0; miso is sampled on the rising edge; mosi changes after the falling edge; MSB first.
- 8-bit mode transmits data_in[7:0].
- fast and wide are captured at start. Changing them during busy affects only the next transfer.
- mosi idles 1.
- done is set at completion. It is cleared by a read of reg 0 or a write of reg 0.
- Engine state machine: IDLE → (start) SHIFT_LO → (DIV cycles) SHIFT_HI → (DIV cycles; if bits remain) SHIFT_LO, or (last bit) IDLE.
- Simultaneous completion and data-register read in the same cycle: the set wins, so done stays 1.

Reset values:
- sclk 0, mosi 1, ss_n all 1
- busy 0, rdy 1, done 0, ovr 0
- rx 0, irq 0
- control register: sel 0, fast 0, wide 0, ien 0

Reset mid-transfer aborts immediately with the reset values above.

## Timing
- Data write accepted at edge k:
  - busy = 1 and the first mosi bit are valid from k+1.
  - sclk rises at k+1+D and falls at k+1+2D, where D = FAST_DIV or SLOW_DIV.
- Transfer length is 2·D·W clocks (W = 8 or 32). busy falls and rx/done are valid at k+1+2·D·W.
- The last sclk falling edge coincides with busy falling.
- Register reads are combinational from registered state. Write effects are visible the cycle after the write edge.

## Configuration
- SDC_IRQ_EN defined: irq = done & ien, registered, so irq asserts one cycle after done.
- SDC_IRQ_EN undefined: irq is tied 0, ien is not stored, and control bit 10 is ignored.

## Structure
- Package sdc_pkg:
  - register addresses SDC_REG_DATA/CTRL/STAT
  - control bit positions (SEL, FAST, WIDE, IEN, CLR_OVR)
  - status bit positions
  - engine state enum
- Sub-module sdc_spi_eng: divider counter, bit counter, shift register and state machine. Inputs: start, div, wide, dataTx. Outputs: dataRx, busy, sclk, mosi, plus a one-cycle completion pulse.
- The top level holds registers, decode, flags and irq.

## Test plan
- Reset, then read status → 0x1; ss_n = all 1, sclk = 0, mosi = 1.
- Control = 0x101 (fast, cs0); write data 0xA5 with miso looped to mosi:
  - busy for 32 cycles (FAST_DIV = 2);
  - 8 sclk pulses on mosi pattern 10100101;
  - reg 0 reads 0x000000A5; done = 1, then 0 after the read.
- Control = 0x302 (fast, wide, cs1); write 0xDEADBEEF, loopback:
  - 128 cycles;
  - ss_n = 2'b01;
  - rx = 0xDEADBEEF.
- Slow 8-bit transfer: sclk high for exactly 63 clk cycles per bit; busy for 1008 cycles.
- Overrun and clear:
  - Write data during busy → rx is unaffected by the second value; status bit 3 (ovr) = 1.
  - Control write with bit 31 → ovr = 0.
- Reset mid-transfer and interrupt:
  - Assert rst at cycle 20 of a transfer → all outputs at reset values next cycle; a new transfer then completes normally.
  - With SDC_IRQ_EN and ien = 1, irq rises one cycle after done and falls after a reg 0 read.

Source files
------------

// File: rtl/sdc_pkg.sv
// sdc_pkg: shared definitions for the sdc_mc multi-channel SPI controller.
//   - register addresses on the word-addressed I/O bus
//   - control and status register bit positions
//   - SPI engine state encoding
package sdc_pkg;

    // Register map (addr[1:0])
    localparam logic [1:0] SDC_REG_DATA = 2'd0;
    localparam logic [1:0] SDC_REG_CTRL = 2'd1;
    localparam logic [1:0] SDC_REG_STAT = 2'd2;

    // Control register bits; SEL occupies [NUM_CS-1:0] starting here
    localparam int CTRL_SEL     = 0;
    localparam int CTRL_FAST    = 8;
    localparam int CTRL_WIDE    = 9;
    localparam int CTRL_IEN     = 10;
    localparam int CTRL_CLR_OVR = 31;

    // Status register bits
    localparam int STAT_RDY  = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_DONE = 2;
    localparam int STAT_OVR  = 3;

    // Engine state: SHIFT_LO is the sclk-low half of a bit, SHIFT_HI the high half
    typedef enum logic [1:0] {
        SDC_IDLE     = 2'd0,
        SDC_SHIFT_LO = 2'd1,
        SDC_SHIFT_HI = 2'd2
    } sdc_state_e;

endpackage

// File: rtl/sdc_mc_if.sv
// sdc_mc_if: RISC5 I/O bus slave port of the SD/SPI controller.
//   stb      bus strobe
//   we       write enable
//   addr     register select (0 data, 1 control, 2 status)
//   data_in  write data
//   data_out read data, 0 when not reading
//   ack      acknowledge (zero wait states)
interface sdc_mc_if;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (output stb, we, addr, data_in, input data_out, ack);
    modport slave  (input stb, we, addr, data_in, output data_out, ack);
endinterface

// File: rtl/sdc_spi_eng.sv
// sdc_spi_eng: SPI mode-0 shift engine (MSB first, 8- or 32-bit).
//   clk, rst  system clock, synchronous active-high reset
//   start     begin a transfer (honoured only when idle)
//   div       sclk half-period in clk cycles (>=1), captured at start
//   wide      1 = 32-bit transfer, 0 = 8-bit, captured at start
//   data_tx   transmit word; 8-bit mode sends data_tx[7:0]
//   miso      serial input, sampled on the sclk rising edge
//   data_rx   received word (8-bit mode: {24'h0, byte}); valid with done_p
//   busy      transfer in progress
//   sclk      SPI clock, idles 0
//   mosi      serial output, idles 1, changes after sclk falls
//   done_p    one-cycle pulse in the final cycle of a transfer
module sdc_spi_eng
    import sdc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] div,
    input  logic        wide,
    input  logic [31:0] data_tx,
    input  logic        miso,
    output logic [31:0] data_rx,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic        done_p
);

    sdc_state_e  state_q, state_d;
    logic [15:0] cnt_q;
    logic [15:0] div_q;
    logic [4:0]  bit_q;
    logic        wide_q;
    logic [31:0] sh_q;
    logic        miso_q;
    logic        sclk_q;
    logic        cnt_end;
    logic        last_bit;

    assign cnt_end  = (cnt_q == div_q - 16'd1);
    assign last_bit = (bit_q == (wide_q ? 5'd31 : 5'd7));

    always_comb begin
        state_d = state_q;
        done_p  = 1'b0;
        case (state_q)
            SDC_IDLE:     if (start) state_d = SDC_SHIFT_LO;
            SDC_SHIFT_LO: if (cnt_end) state_d = SDC_SHIFT_HI;
            SDC_SHIFT_HI: begin
                if (cnt_end) begin
                    state_d = last_bit ? SDC_IDLE : SDC_SHIFT_LO;
                    done_p  = last_bit;
                end
            end
            default:      state_d = SDC_IDLE;
        endcase
    end

    // Transmit and receive share one shift register: the outgoing MSB drives
    // mosi while the sampled miso bit enters at the LSB on each falling edge.
    // An 8-bit word is loaded left-justified so that after 8 shifts the
    // received byte sits in [7:0] with zeros above it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SDC_IDLE;
            cnt_q   <= '0;
            div_q   <= 16'd1;
            bit_q   <= '0;
            wide_q  <= 1'b0;
            sh_q    <= '0;
            miso_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sclk_q  <= (state_d == SDC_SHIFT_HI);
            case (state_q)
                SDC_IDLE: begin
                    if (start) begin
                        sh_q   <= wide ? data_tx : {data_tx[7:0], 24'h0};
                        cnt_q  <= '0;
                        bit_q  <= '0;
                        div_q  <= div;
                        wide_q <= wide;
                    end
                end
                SDC_SHIFT_LO: begin
                    cnt_q <= cnt_end ? 16'd0 : cnt_q + 16'd1;
                    if (cnt_end) miso_q <= miso;
                end
                SDC_SHIFT_HI: begin
                    cnt_q <= cnt_end ? 16'd0 : cnt_q + 16'd1;
                    if (cnt_end) begin
                        sh_q  <= {sh_q[30:0], miso_q};
                        bit_q <= bit_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The final shift lands on the same edge as done_p, so present the
    // post-shift word while done_p is high.
    assign data_rx = wide_q ? {sh_q[30:0], miso_q} : {24'h0, sh_q[6:0], miso_q};
    assign busy    = (state_q != SDC_IDLE);
    assign sclk    = sclk_q;
    assign mosi    = (state_q == SDC_IDLE) ? 1'b1 : sh_q[31];

endmodule

// File: rtl/sdc_mc.sv
// sdc_mc: multi-channel SPI controller (SD cards and other SPI peripherals)
// on the RISC5 I/O bus. Three word-addressed registers: data, control, status.
//   clk, rst  system clock, synchronous active-high reset
//   bus       sdc_mc_if.slave: stb, we, addr, data_in, data_out, ack
//   ss_n      active-low chip selects, ss_n = ~sel
//   sclk      SPI clock, mode 0
//   mosi      SPI data out
//   miso      SPI data in
//   irq       completion interrupt
// Optional feature: define SDC_IRQ_EN to store ien (control bit 10) and
// drive irq = done & ien, registered. Without it irq is tied 0.
module sdc_mc
    import sdc_pkg::*;
#(
    parameter int NUM_CS   = 2,
    parameter int SLOW_DIV = 63,
    parameter int FAST_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    sdc_mc_if.slave           bus,
    output logic [NUM_CS-1:0] ss_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              irq
);

    logic [NUM_CS-1:0] sel_q;
    logic              fast_q;
    logic              wide_q;
    logic              ovr_q;
    logic              done_q;
    logic [31:0]       rx_q;

    logic        wr_data, wr_ctrl, rd_data;
    logic        start, busy, done_p;
    logic [31:0] data_rx;
    logic [15:0] div;

    assign wr_data = bus.stb &  bus.we & (bus.addr == SDC_REG_DATA);
    assign wr_ctrl = bus.stb &  bus.we & (bus.addr == SDC_REG_CTRL);
    assign rd_data = bus.stb & ~bus.we & (bus.addr == SDC_REG_DATA);
    assign start   = wr_data & ~busy;
    assign div     = fast_q ? 16'(FAST_DIV) : 16'(SLOW_DIV);

    sdc_spi_eng u_eng (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .div     (div),
        .wide    (wide_q),
        .data_tx (bus.data_in),
        .miso    (miso),
        .data_rx (data_rx),
        .busy    (busy),
        .sclk    (sclk),
        .mosi    (mosi),
        .done_p  (done_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            fast_q <= 1'b0;
            wide_q <= 1'b0;
            ovr_q  <= 1'b0;
            done_q <= 1'b0;
            rx_q   <= '0;
        end else begin
            if (wr_ctrl) begin
                sel_q  <= bus.data_in[CTRL_SEL +: NUM_CS];
                fast_q <= bus.data_in[CTRL_FAST];
                wide_q <= bus.data_in[CTRL_WIDE];
            end
            // Data write and control write never coincide, so order is moot
            if (wr_data && busy)
                ovr_q <= 1'b1;
            else if (wr_ctrl && bus.data_in[CTRL_CLR_OVR])
                ovr_q <= 1'b0;
            // Completion beats a same-cycle clearing access
            if (done_p) begin
                done_q <= 1'b1;
                rx_q   <= data_rx;
            end else if (wr_data || rd_data) begin
                done_q <= 1'b0;
            end
        end
    end

`ifdef SDC_IRQ_EN
    logic ien_q;
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ien_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_ctrl) ien_q <= bus.data_in[CTRL_IEN];
            irq_q <= done_q & ien_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        bus.data_out = '0;
        if (bus.stb && !bus.we) begin
            case (bus.addr)
                SDC_REG_DATA: bus.data_out = rx_q;
                SDC_REG_STAT: bus.data_out = {28'h0, ovr_q, done_q, busy, ~busy};
                default:      bus.data_out = '0;
            endcase
        end
    end

    assign bus.ack = bus.stb;
    assign ss_n    = ~sel_q;

endmodule

// File: tb/tb_sdc_mc.sv
// tb_sdc_mc: self-checking bench for sdc_mc with miso looped back to mosi.
// Expected receive words go into a scoreboard queue when a transfer is
// started and are popped when the data register is read after completion.
module tb_sdc_mc;
    import sdc_pkg::*;

    localparam int NUM_CS   = 2;
    localparam int SLOW_DIV = 63;
    localparam int FAST_DIV = 2;
    localparam int TIMEOUT  = 5000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CS-1:0] ss_n;
    logic              sclk, mosi, miso, irq;

    sdc_mc_if bus ();

    sdc_mc #(
        .NUM_CS   (NUM_CS),
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .ss_n (ss_n),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso),
        .irq  (irq)
    );

    always #5 clk = ~clk;
    assign miso = mosi;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] exp_q[$];

    // transfer monitor results
    int          m_cyc, m_pulses, m_hi_min, m_hi_max;
    logic [31:0] m_pat;
    logic [NUM_CS-1:0] m_ss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.stb = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
        @(posedge clk); #1;
        bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.stb = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1 d = bus.data_out;
        @(posedge clk); #1;
        bus.stb = 1'b0;
    endtask

    // Poll status (side-effect free) once per cycle until busy drops,
    // recording sclk pulses, their high time and the mosi bit at each rise.
    task automatic monitor();
        logic prev;
        int   hi;
        m_cyc = 0; m_pulses = 0; m_hi_min = 99999; m_hi_max = 0; m_pat = '0;
        prev = 1'b0; hi = 0;
        bus.stb = 1'b1; bus.we = 1'b0; bus.addr = SDC_REG_STAT;
        #1;
        while (bus.data_out[STAT_BUSY] && m_cyc < TIMEOUT) begin
            if (sclk) begin
                if (!prev) begin
                    m_pulses++;
                    m_pat = {m_pat[30:0], mosi};
                end
                hi++;
            end else if (prev) begin
                if (hi < m_hi_min) m_hi_min = hi;
                if (hi > m_hi_max) m_hi_max = hi;
                hi = 0;
            end
            m_ss = ss_n;
            prev = sclk;
            @(posedge clk); #2;
            m_cyc++;
        end
        if (prev && !sclk) begin
            if (hi < m_hi_min) m_hi_min = hi;
            if (hi > m_hi_max) m_hi_max = hi;
        end
        if (m_cyc >= TIMEOUT) chk("busy_timeout", 32'(m_cyc), 32'(0));
        bus.stb = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] ctrl, input logic [31:0] d);
        bus_wr(SDC_REG_CTRL, ctrl);
        bus_wr(SDC_REG_DATA, d);
        exp_q.push_back(ctrl[CTRL_WIDE] ? d : {24'h0, d[7:0]});
    endtask

    task automatic check_rx(input logic [31:0] stat_exp);
        logic [31:0] rd;
        logic [31:0] e;
        bus_rd(SDC_REG_STAT, rd);
        chk("stat_done", rd, stat_exp);
        bus_rd(SDC_REG_DATA, rd);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'(exp_q.size()), 32'(1));
        end else begin
            e = exp_q.pop_front();
            chk("rx", rd, e);
        end
        bus_rd(SDC_REG_STAT, rd);
        chk("stat_after_rd", rd & 32'h4, 32'h0);
    endtask

    task automatic run_xfer(input logic [31:0] ctrl, input logic [31:0] d);
        int d_div, w;
        logic [NUM_CS-1:0] ss_exp;
        d_div  = ctrl[CTRL_FAST] ? FAST_DIV : SLOW_DIV;
        w      = ctrl[CTRL_WIDE] ? 32 : 8;
        ss_exp = ~ctrl[NUM_CS-1:0];
        start_xfer(ctrl, d);
        monitor();
        chk("busy_cycles", 32'(m_cyc), 32'(2 * d_div * w));
        chk("sclk_pulses", 32'(m_pulses), 32'(w));
        chk("sclk_hi_min", 32'(m_hi_min), 32'(d_div));
        chk("sclk_hi_max", 32'(m_hi_max), 32'(d_div));
        chk("mosi_pattern", m_pat, (w == 32) ? d : {24'h0, d[7:0]});
        chk("ss_n_busy", 32'(m_ss), 32'(ss_exp));
        check_rx(32'h5);
        chk("mosi_idle", 32'(mosi), 32'(1));
        chk("sclk_idle", 32'(sclk), 32'(0));
    endtask

    initial begin
        logic [31:0] rd;
        bus.stb = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("data_out_idle", bus.data_out, 32'h0);
        chk("ss_n_rst", 32'(ss_n), 32'(2'b11));
        chk("sclk_rst", 32'(sclk), 32'(0));
        chk("mosi_rst", 32'(mosi), 32'(1));
        chk("irq_rst", 32'(irq), 32'(0));
        bus_rd(SDC_REG_STAT, rd);
        chk("stat_rst", rd, 32'h1);
        bus_rd(SDC_REG_DATA, rd);
        chk("rx_rst", rd, 32'h0);

        // fast 8-bit on cs0, fast 32-bit on cs1
        run_xfer(32'h0000_0101, 32'h0000_00A5);
        bus_rd(SDC_REG_CTRL, rd);
        chk("ctrl_rd_zero", rd, 32'h0);
        run_xfer(32'h0000_0302, 32'hDEAD_BEEF);
        run_xfer(32'h0000_0103, 32'h1234_5678);

        // slow 8-bit
        run_xfer(32'h0000_0001, 32'hFFFF_FF3C);

        // overrun: second write while busy is dropped and flagged
        start_xfer(32'h0000_0101, 32'h0000_00C3);
        bus_wr(SDC_REG_DATA, 32'h0000_0018);
        monitor();
        check_rx(32'hD);
        bus_rd(SDC_REG_STAT, rd);
        chk("ovr_sticky", rd & 32'h8, 32'h8);
        bus_wr(SDC_REG_CTRL, 32'h8000_0101);
        bus_rd(SDC_REG_STAT, rd);
        chk("ovr_clear", rd, 32'h1);

        // reset mid-transfer
        start_xfer(32'h0000_0102, 32'h0000_005A);
        repeat (19) @(posedge clk);
        #1;
        bus_rd(SDC_REG_STAT, rd);
        chk("busy_before_rst", rd & 32'h2, 32'h2);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("sclk_mid_rst", 32'(sclk), 32'(0));
        chk("mosi_mid_rst", 32'(mosi), 32'(1));
        chk("ss_n_mid_rst", 32'(ss_n), 32'(2'b11));
        chk("irq_mid_rst", 32'(irq), 32'(0));
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        bus_rd(SDC_REG_STAT, rd);
        chk("stat_mid_rst", rd, 32'h1);
        bus_rd(SDC_REG_DATA, rd);
        chk("rx_mid_rst", rd, 32'h0);
        run_xfer(32'h0000_0101, 32'h0000_0069);

        // completion interrupt
        start_xfer(32'h0000_0501, 32'h0000_0081);
        monitor();
        chk("irq_at_done", 32'(irq), 32'(0));
        @(posedge clk); #1;
`ifdef SDC_IRQ_EN
        chk("irq_rise", 32'(irq), 32'(1));
`else
        chk("irq_tied", 32'(irq), 32'(0));
`endif
        bus_rd(SDC_REG_DATA, rd);
        chk("rx_irq", rd, exp_q.pop_front());
        @(posedge clk); #1;
        chk("irq_fall", 32'(irq), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
